// File: rtl/debug_ctrl_bp_pkg.sv
// Shared types and constants for the debug run-control block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package debug_ctrl_bp_pkg;

   // Encoding is reported directly in STATUS[1:0].
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_HALTED   = 2'd1,
      ST_STEPPING = 2'd2,
      ST_ACCESS   = 2'd3
   } state_e;

   localparam logic [3:0] REG_CTRL   = 4'd0;
   localparam logic [3:0] REG_ADDR   = 4'd1;
   localparam logic [3:0] REG_WDATA  = 4'd2;
   localparam logic [3:0] REG_RDATA  = 4'd3;
   localparam logic [3:0] REG_STATUS = 4'd4;
   localparam logic [3:0] REG_STEP   = 4'd5;
   localparam logic [3:0] REG_BP0    = 4'd6;

   localparam logic [2:0] MODE_RD_MEM = 3'd1;
   localparam logic [2:0] MODE_WR_MEM = 3'd2;
   localparam logic [2:0] MODE_RD_REG = 3'd5;
   localparam logic [2:0] MODE_WR_REG = 3'd6;
   localparam logic [2:0] MODE_IDLE   = 3'b100;

   // Modes that need a bridge transfer (and therefore a doneSending handshake).
   function automatic logic is_handshake(input logic [2:0] m);
      return (m == MODE_RD_MEM) || (m == MODE_WR_MEM) ||
             (m == MODE_RD_REG) || (m == MODE_WR_REG);
   endfunction

endpackage

// File: rtl/debug_ctrl_bp_if.sv
// Avalon-MM debug slave bus bundle.
// Latency: readdata valid one cycle after a read strobe.
// Backpressure: none (no waitrequest).
interface debug_ctrl_bp_if #(parameter int DATA_W = 32);
   logic              chipselect;
   logic              write;
   logic              read;
   logic [3:0]        address;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;

   modport master (output chipselect, write, read, address, writedata, input readdata);
   modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/debug_ctrl_bp_regs.sv
// Avalon register file: CTRL/ADDR/WDATA/STEP/BP storage, read mux.
// Latency: writes land on the next edge; readdata registered, 1 cycle.
// Backpressure: none; go bits written during ACCESS are discarded.
module debug_ctrl_bp_regs
   import debug_ctrl_bp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int STEP_W = 8,
   parameter int NUM_BP = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   debug_ctrl_bp_if.slave                bus,
   input  logic                          in_access,
   input  logic                          set_halt,
   input  logic [DATA_W-1:0]             status,
   input  logic [DATA_W-1:0]             rdata,
   output logic                          halt,
   output logic                          step_go,
   output logic                          access_go,
   output logic [2:0]                    ctrl_mode,
   output logic [NUM_BP-1:0]             bp_en,
   output logic [DATA_W-1:0]             addr,
   output logic [DATA_W-1:0]             wdata,
   output logic [STEP_W-1:0]             step,
   output logic [NUM_BP-1:0][DATA_W-1:0] bp_addr
);
   logic                          halt_q, halt_d;
   logic                          step_go_q, step_go_d;
   logic                          access_go_q, access_go_d;
   logic [2:0]                    ctrl_mode_q, ctrl_mode_d;
   logic [NUM_BP-1:0]             bp_en_q, bp_en_d;
   logic [DATA_W-1:0]             addr_q, addr_d;
   logic [DATA_W-1:0]             wdata_q, wdata_d;
   logic [STEP_W-1:0]             step_q, step_d;
   logic [NUM_BP-1:0][DATA_W-1:0] bp_addr_q, bp_addr_d;
   logic [DATA_W-1:0]             readdata_q, readdata_d;
   logic                          wr, rd;

   assign wr = bus.chipselect & bus.write;
   assign rd = bus.chipselect & bus.read;

   // Register writes; go bits live for one cycle only.
   always_comb begin
      halt_d      = halt_q;
      step_go_d   = 1'b0;
      access_go_d = 1'b0;
      ctrl_mode_d = ctrl_mode_q;
      bp_en_d     = bp_en_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      step_d      = step_q;
      bp_addr_d   = bp_addr_q;
      if (wr) begin
         case (bus.address)
            REG_CTRL: begin
               halt_d      = bus.writedata[0];
               step_go_d   = bus.writedata[1] & ~in_access;
               access_go_d = bus.writedata[2] & ~in_access;
               ctrl_mode_d = bus.writedata[6:4];
               bp_en_d     = bus.writedata[8 +: NUM_BP];
            end
            REG_ADDR:  addr_d  = bus.writedata;
            REG_WDATA: wdata_d = bus.writedata;
            REG_STEP:  step_d  = bus.writedata[STEP_W-1:0];
            default: ;
         endcase
         for (int i = 0; i < NUM_BP; i++) begin
            if (bus.address == 4'(REG_BP0 + i)) bp_addr_d[i] = bus.writedata;
         end
      end
      // A breakpoint hit latches halt so the core stays stopped until the
      // debugger explicitly clears it; it overrides a coincident CTRL write.
      if (set_halt) halt_d = 1'b1;
   end

   // Read mux, captured on a read strobe and held otherwise.
   always_comb begin
      readdata_d = readdata_q;
      if (rd) begin
         readdata_d = '0;
         case (bus.address)
            REG_CTRL: begin
               readdata_d[0]            = halt_q;
               readdata_d[6:4]          = ctrl_mode_q;
               readdata_d[8 +: NUM_BP]  = bp_en_q;
            end
            REG_ADDR:   readdata_d = addr_q;
            REG_WDATA:  readdata_d = wdata_q;
            REG_RDATA:  readdata_d = rdata;
            REG_STATUS: readdata_d = status;
            REG_STEP:   readdata_d[STEP_W-1:0] = step_q;
            default: ;
         endcase
         for (int i = 0; i < NUM_BP; i++) begin
            if (bus.address == 4'(REG_BP0 + i)) readdata_d = bp_addr_q[i];
         end
      end
   end

   // Register state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         halt_q      <= 1'b0;
         step_go_q   <= 1'b0;
         access_go_q <= 1'b0;
         ctrl_mode_q <= '0;
         bp_en_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         step_q      <= '0;
         bp_addr_q   <= '0;
         readdata_q  <= '0;
      end else begin
         halt_q      <= halt_d;
         step_go_q   <= step_go_d;
         access_go_q <= access_go_d;
         ctrl_mode_q <= ctrl_mode_d;
         bp_en_q     <= bp_en_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         step_q      <= step_d;
         bp_addr_q   <= bp_addr_d;
         readdata_q  <= readdata_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign halt         = halt_q;
   assign step_go      = step_go_q;
   assign access_go    = access_go_q;
   assign ctrl_mode    = ctrl_mode_q;
   assign bp_en        = bp_en_q;
   assign addr         = addr_q;
   assign wdata        = wdata_q;
   assign step         = step_q;
   assign bp_addr      = bp_addr_q;

endmodule

// File: rtl/debug_ctrl_bp.sv
// Run-control FSM: run/halt, N-step, PC breakpoints, bridge access with timeout.
// Latency: all outputs registered; state change visible one cycle after decision.
// Backpressure: ACCESS waits for doneSending up to TIMEOUT cycles.
module debug_ctrl_bp
   import debug_ctrl_bp_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int STEP_W  = 8,
   parameter int NUM_BP  = 4,
   parameter int NUM_EN  = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic              CLK,
   input  logic              RST,
   debug_ctrl_bp_if.slave    avl,
   input  logic [DATA_W-1:0] pc_in,
   input  logic              enableStep,
   input  logic [DATA_W-1:0] data_internal,
   input  logic              doneSending,
   output logic              debug,
   output logic [NUM_EN-1:0] enable_ext,
   output logic              enable_pc_ext,
   output logic              tx_flag,
   output logic [2:0]        mode,
   output logic [DATA_W-1:0] address_bridged,
   output logic [DATA_W-1:0] data_bridged
);
   localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic                          halt, step_go, access_go;
   logic [2:0]                    ctrl_mode;
   logic [NUM_BP-1:0]             bp_en;
   logic [STEP_W-1:0]             step;
   logic [NUM_BP-1:0][DATA_W-1:0] bp_addr;
   logic [DATA_W-1:0]             status;
   logic                          bp_match, set_halt;
   logic [2:0]                    bp_sel;
   logic [STEP_W-1:0]             cnt_inc;

   state_e            state_q, state_d;
   logic [STEP_W-1:0] cnt_q, cnt_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              bp_hit_q, bp_hit_d;
   logic [2:0]        bp_idx_q, bp_idx_d;
   logic              timeout_q, timeout_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [2:0]        mode_q, mode_d;
   logic              en_q, en_d;
   logic              debug_q, debug_d;
   logic              tx_q, tx_d;

   debug_ctrl_bp_regs #(.DATA_W(DATA_W), .STEP_W(STEP_W), .NUM_BP(NUM_BP)) u_regs (
      .CLK(CLK), .RST(RST), .bus(avl),
      .in_access(state_q == ST_ACCESS), .set_halt(set_halt),
      .status(status), .rdata(rdata_q),
      .halt(halt), .step_go(step_go), .access_go(access_go),
      .ctrl_mode(ctrl_mode), .bp_en(bp_en), .addr(address_bridged),
      .wdata(data_bridged), .step(step), .bp_addr(bp_addr)
   );

   // Breakpoint comparators; descending scan so the lowest index wins.
   always_comb begin
      bp_match = 1'b0;
      bp_sel   = '0;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (enableStep && bp_en[i] && (pc_in == bp_addr[i])) begin
            bp_match = 1'b1;
            bp_sel   = 3'(i);
         end
      end
   end

   assign set_halt = bp_match && ((state_q == ST_RUN) || (state_q == ST_STEPPING));
   assign cnt_inc  = cnt_q + STEP_W'(1);

   // Next-state and registered-output computation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      bp_hit_d  = bp_hit_q;
      bp_idx_d  = bp_idx_q;
      timeout_d = timeout_q;
      rdata_d   = rdata_q;
      mode_d    = mode_q;
      case (state_q)
         ST_RUN: begin
            if (bp_match) begin
               state_d  = ST_HALTED;
               bp_hit_d = 1'b1;
               bp_idx_d = bp_sel;
            end else if (halt) begin
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            if (access_go) begin
               mode_d = ctrl_mode;
               if (is_handshake(ctrl_mode)) begin
                  state_d = ST_ACCESS;
                  tmo_d   = '0;
               end
            end else if (step_go && (step != '0)) begin
               state_d = ST_STEPPING;
               cnt_d   = '0;
            end else if (!halt) begin
               state_d   = ST_RUN;
               bp_hit_d  = 1'b0;
               timeout_d = 1'b0;
            end
         end
         ST_STEPPING: begin
            if (enableStep) begin
               cnt_d = cnt_inc;
               if (bp_match) begin
                  state_d  = ST_HALTED;
                  bp_hit_d = 1'b1;
                  bp_idx_d = bp_sel;
               end else if (cnt_inc == step) begin
                  state_d = ST_HALTED;
               end
            end
         end
         ST_ACCESS: begin
            if (doneSending) begin
               rdata_d = data_internal;
               state_d = ST_HALTED;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               state_d   = ST_HALTED;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
      en_d    = (state_d == ST_RUN) || (state_d == ST_STEPPING);
      debug_d = (state_d != ST_RUN);
      tx_d    = (state_d == ST_ACCESS);
   end

   // FSM and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         tmo_q     <= '0;
         bp_hit_q  <= 1'b0;
         bp_idx_q  <= '0;
         timeout_q <= 1'b0;
         rdata_q   <= '0;
         mode_q    <= MODE_IDLE;
         en_q      <= 1'b0;
         debug_q   <= 1'b0;
         tx_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         bp_hit_q  <= bp_hit_d;
         bp_idx_q  <= bp_idx_d;
         timeout_q <= timeout_d;
         rdata_q   <= rdata_d;
         mode_q    <= mode_d;
         en_q      <= en_d;
         debug_q   <= debug_d;
         tx_q      <= tx_d;
      end
   end

   // STATUS word assembly.
   always_comb begin
      status               = '0;
      status[1:0]          = state_q;
      status[2]            = bp_hit_q;
      status[6:4]          = bp_idx_q;
      status[7]            = timeout_q;
      status[8 +: STEP_W]  = cnt_q;
   end

   assign debug         = debug_q;
   assign enable_ext    = {NUM_EN{en_q}};
   assign enable_pc_ext = en_q;
   assign tx_flag       = tx_q;
   assign mode          = mode_q;

endmodule

// File: tb/tb_debug_ctrl_bp.sv
module tb_debug_ctrl_bp;
   localparam int DATA_W  = 32;
   localparam int STEP_W  = 8;
   localparam int NUM_BP  = 4;
   localparam int NUM_EN  = 4;
   localparam int TIMEOUT = 16;

   logic              CLK = 1'b0;
   logic              RST;
   logic [DATA_W-1:0] pc_in;
   logic              enableStep;
   logic [DATA_W-1:0] data_internal;
   logic              doneSending;
   logic              debug;
   logic [NUM_EN-1:0] enable_ext;
   logic              enable_pc_ext;
   logic              tx_flag;
   logic [2:0]        mode;
   logic [DATA_W-1:0] address_bridged;
   logic [DATA_W-1:0] data_bridged;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] rd;
   int hi;

   debug_ctrl_bp_if #(.DATA_W(DATA_W)) avl ();

   debug_ctrl_bp #(
      .DATA_W(DATA_W), .STEP_W(STEP_W), .NUM_BP(NUM_BP),
      .NUM_EN(NUM_EN), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK(CLK), .RST(RST), .avl(avl),
      .pc_in(pc_in), .enableStep(enableStep),
      .data_internal(data_internal), .doneSending(doneSending),
      .debug(debug), .enable_ext(enable_ext), .enable_pc_ext(enable_pc_ext),
      .tx_flag(tx_flag), .mode(mode),
      .address_bridged(address_bridged), .data_bridged(data_bridged)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic avl_write(input logic [3:0] a, input logic [31:0] d);
      avl.chipselect = 1'b1;
      avl.write      = 1'b1;
      avl.address    = a;
      avl.writedata  = d;
      tick();
      avl.chipselect = 1'b0;
      avl.write      = 1'b0;
   endtask

   task automatic avl_read(input logic [3:0] a, output logic [31:0] d);
      avl.chipselect = 1'b1;
      avl.read       = 1'b1;
      avl.address    = a;
      tick();
      d = avl.readdata;
      avl.chipselect = 1'b0;
      avl.read       = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      avl.chipselect = 1'b0; avl.write = 1'b0; avl.read = 1'b0;
      avl.address = '0; avl.writedata = '0;
      pc_in = '0; enableStep = 1'b0; data_internal = '0; doneSending = 1'b0;
      tick(); tick();

      // Reset state
      check("rst_enable", 32'(enable_ext), 32'h0);
      check("rst_mode", 32'(mode), 32'h4);
      check("rst_tx", 32'(tx_flag), 32'h0);
      check("rst_debug", 32'(debug), 32'h0);
      check("rst_readdata", avl.readdata, 32'h0);
      RST = 1'b0;
      tick();
      check("run_enable", 32'(enable_ext), 32'hF);
      check("run_pc_en", 32'(enable_pc_ext), 32'h1);
      check("run_mode_held", 32'(mode), 32'h4);

      // Halt, then step 3 of 5 retirements
      avl_write(4'd0, 32'h1);
      tick();
      check("halt_enable", 32'(enable_ext), 32'h0);
      check("halt_debug", 32'(debug), 32'h1);
      avl_read(4'd4, rd);
      check("halt_status", rd, 32'h1);
      avl_write(4'd5, 32'd3);
      avl_write(4'd0, 32'h3);
      tick();
      check("step_enable_on", 32'(enable_ext), 32'hF);
      for (int k = 1; k <= 5; k++) begin
         enableStep = 1'b1;
         tick();
         enableStep = 1'b0;
         if (k == 2) check("step2_enable", 32'(enable_ext), 32'hF);
         if (k == 3) check("step3_enable", 32'(enable_ext), 32'h0);
      end
      avl_read(4'd4, rd);
      check("step_status", rd, 32'h301);

      // Breakpoint 1 at 0x100
      avl_write(4'd7, 32'h100);
      avl_write(4'd0, 32'h200);
      tick();
      check("bp_resume_enable", 32'(enable_ext), 32'hF);
      pc_in = 32'h104; enableStep = 1'b1;
      tick();
      enableStep = 1'b0;
      check("bp_nomatch_enable", 32'(enable_ext), 32'hF);
      pc_in = 32'h100; enableStep = 1'b1;
      tick();
      enableStep = 1'b0;
      check("bp_hit_enable", 32'(enable_ext), 32'h0);
      tick(); tick();
      check("bp_stays_halted", 32'(enable_ext), 32'h0);
      avl_read(4'd4, rd);
      check("bp_status", rd, 32'h315);
      avl_read(4'd0, rd);
      check("bp_ctrl_halt", rd, 32'h201);
      avl_write(4'd0, 32'h200);
      tick();
      check("bp_clear_enable", 32'(enable_ext), 32'hF);
      avl_read(4'd4, rd);
      check("bp_clear_status", rd, 32'h310);

      // Bridge access, doneSending in 7th cycle
      avl_write(4'd0, 32'h1);
      avl_write(4'd1, 32'h40);
      avl_write(4'd2, 32'h1234);
      check("addr_bridged", address_bridged, 32'h40);
      check("data_bridged", data_bridged, 32'h1234);
      avl_write(4'd0, 32'h15);
      hi = 0;
      for (int j = 0; j < 7; j++) begin
         tick();
         if (tx_flag) hi++;
         if (j == 0) check("acc_mode", 32'(mode), 32'h1);
         if (j == 6) begin
            doneSending = 1'b1;
            data_internal = 32'hDEADBEEF;
         end
      end
      tick();
      doneSending = 1'b0;
      data_internal = '0;
      check("acc_tx_low", 32'(tx_flag), 32'h0);
      check("acc_tx_cycles", 32'(hi), 32'd7);
      avl_read(4'd3, rd);
      check("acc_rdata", rd, 32'hDEADBEEF);

      // Access without doneSending times out after 16 cycles
      avl_write(4'd0, 32'h15);
      hi = 0;
      for (int j = 0; j < 20; j++) begin
         tick();
         if (tx_flag) hi++;
      end
      check("tmo_tx_cycles", 32'(hi), 32'd16);
      avl_read(4'd4, rd);
      check("tmo_status", rd, 32'h391);
      avl_read(4'd3, rd);
      check("tmo_rdata_kept", rd, 32'hDEADBEEF);

      // Non-handshake mode: apply only
      avl_write(4'd0, 32'h35);
      tick();
      check("mode3_mode", 32'(mode), 32'h3);
      check("mode3_tx", 32'(tx_flag), 32'h0);

      // step_go with STEP=0 is ignored
      avl_write(4'd5, 32'd0);
      avl_write(4'd0, 32'h3);
      tick();
      check("step0_enable", 32'(enable_ext), 32'h0);
      avl_read(4'd4, rd);
      check("step0_status", rd, 32'h391);
      avl_write(4'd0, 32'h0);
      tick();
      avl_read(4'd4, rd);
      check("resume_clears_tmo", rd, 32'h310);

      // Reset in the middle of an access
      avl_write(4'd0, 32'h1);
      avl_write(4'd0, 32'h15);
      tick(); tick();
      check("rst_acc_tx_high", 32'(tx_flag), 32'h1);
      RST = 1'b1;
      #2;
      check("rst_acc_tx_drop", 32'(tx_flag), 32'h0);
      tick();
      RST = 1'b0;
      tick();
      check("rst_acc_enable", 32'(enable_ext), 32'hF);
      check("rst_acc_debug", 32'(debug), 32'h0);
      avl_read(4'd3, rd);
      check("rst_acc_rdata", rd, 32'h0);

      // Lowest matching breakpoint index wins
      avl_write(4'd6, 32'h200);
      avl_write(4'd8, 32'h200);
      avl_write(4'd0, 32'h500);
      tick();
      pc_in = 32'h200; enableStep = 1'b1;
      tick();
      enableStep = 1'b0;
      avl_read(4'd4, rd);
      check("bp_lowest_status", rd, 32'h5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/debug_ctrl_bp.md
# debug_ctrl_bp

Parametrised run-control and debug-access controller for the RISC-V core, sitting between the Avalon-MM debug slave port and the core's enable, PC-enable and bridge signals. It adds N-instruction stepping with a configurable step-counter width, NUM_BP hardware PC breakpoints, sticky status and an access-handshake timeout. The block gates all core stage enables and drives memory/register transfers over the address/data bridge.

## Interface
- DATA_W, 32, data/address/PC width
- STEP_W, 8, step-count width; max step N = 2^STEP_W-1
- NUM_BP, 4, hardware breakpoints, 1..8
- NUM_EN, 4, stage-enable outputs
- TIMEOUT, 1024, max cycles ACCESS waits for doneSending; min 2
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- chipselect, write, read  in  1  Avalon-MM slave strobes
- address  in  4  word offset
- writedata  in  DATA_W  Avalon write data
- readdata  out  DATA_W  Avalon read data, registered
- pc_in  in  DATA_W  PC of the instruction retiring this cycle
- enableStep  in  1  one-cycle pulse per retired instruction
- data_internal  in  DATA_W  data returned by the bridge
- doneSending  in  1  bridge transfer complete
- debug  out  1  high whenever the state is not RUN
- enable_ext  out  NUM_EN  stage enables, all bits equal
- enable_pc_ext  out  1  PC enable
- tx_flag  out  1  bridge request
- mode  out  3  bridge mode code
- address_bridged, data_bridged  out  DATA_W  ADDR and WDATA registers

## Operation
- Register map:
  - 0 CTRL: [0] halt; [1] step_go, self-clearing; [2] access_go, self-clearing; [6:4] access mode; [8+i] bp_en[i].
  - 1 ADDR; 2 WDATA; 3 RDATA (read-only); 5 STEP[STEP_W-1:0].
  - 4 STATUS (read-only): [1:0] state; [2] bp_hit, sticky; [6:4] bp_idx; [7] timeout, sticky; [8+STEP_W-1:8] step count.
  - 6..6+NUM_BP-1 BP address.
  - Unmapped reads return 0; unmapped writes are ignored.
- States:
  - RUN: enables=1. Goes to HALTED when halt=1, or on enableStep with pc_in==BP[i] and bp_en[i]. On a breakpoint match, set bp_hit and latch the lowest matching i into bp_idx.
  - HALTED: enables=0, mode=CTRL mode, tx_flag=0. Exits in priority order:
    - access_go with mode ∈ {1,2,5,6}: go to ACCESS.
    - access_go with mode 3, 4 or 0: apply mode only and stay.
    - step_go with STEP≠0: go to STEPPING and clear the step count. step_go with STEP=0 is ignored.
    - halt=0: go to RUN and clear bp_hit and timeout.
  - STEPPING: enables=1. enableStep increments the count. Go to HALTED when count+1==STEP on an enableStep cycle, or on a breakpoint match (breakpoint wins and sets bp_hit).
  - ACCESS: tx_flag=1, mode held, enables=0.
    - On doneSending: RDATA←data_internal, go to HALTED.
    - After TIMEOUT cycles without doneSending: set timeout, go to HALTED, leave RDATA unchanged.
- CTRL writes during ACCESS update fields, but the go bits are dropped.
- Step counter is STEP_W bits and never wraps, because the terminal compare fires first.

## Timing
- Reset values:
  - readdata=0, debug=0, enable_ext=0, enable_pc_ext=0, tx_flag=0, mode=3'b100, address_bridged=0, data_bridged=0.
  - All registers 0; state RUN.
- First cycle after reset release: enables go to 1.
- Outputs are registered. A state change is visible on outputs one cycle after the deciding edge.
  - Example: a breakpoint match on cycle t gives enables=0 from t+1.
- Avalon writes take effect on the next edge. Read latency is 1 cycle, no waitrequest.
- tx_flag deasserts the cycle after doneSending is sampled.
- Breakpoint match and halt in the same cycle: go to HALTED and set bp_hit.
- doneSending and timeout expiry in the same cycle: done wins, timeout stays clear.
- RST mid-ACCESS: tx_flag drops immediately (asynchronous); no RDATA update.

## Structure
- debug_pkg holds:
  - the state enum {RUN, HALTED, STEPPING, ACCESS}, encoded 0..3 for STATUS;
  - register offset constants;
  - mode codes and the handshake-mode set.
- Sub-module debug_regs: Avalon register file with self-clearing go bits and registered readdata.
- Top level holds the FSM, breakpoint comparators, step counter and timeout counter.

## Test plan
- Reset, then idle: enables=0 during RST, enables=1 one cycle after release, mode=3'b100 held until the first access.
- Halt, STEP=3, step_go, then 5 enableStep pulses: exactly 3 counted, enables drop after the 3rd, STATUS.count=3.
- BP1=0x100 with bp_en=0b0010, retire pc_in=0x100: HALTED, bp_hit=1, bp_idx=1; halt=0 resumes and clears bp_hit.
- Halted, ADDR=0x40, mode=1, access_go, doneSending after 7 cycles with data_internal=0xDEADBEEF: tx_flag high for 7 cycles, RDATA=0xDEADBEEF.
- TIMEOUT=16, access with no doneSending: tx_flag low after 16 cycles, STATUS.timeout=1, RDATA unchanged.
- Assert RST mid-ACCESS: tx_flag=0 immediately, state RUN after release.
